// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue -- instruction fetch unit with a prefetch queue (Minisys core)
//
// Issues word reads to a synchronous instruction ROM and buffers each
// returned word, together with its PC, in a DEPTH-entry FIFO. Decode takes
// the queue head over a valid/ready handshake. A single redirect port
// restarts fetch at a new PC and flushes everything already fetched.
//
// Optional feature macro: IFETCH_MISALIGN_EN
//   defined   : adds misalign_o. A redirect to a PC with [1:0] != 0 halts
//               fetch until the next aligned redirect or reset.
//   undefined : redirect_pc_i[1:0] is ignored (fetch PC forced word aligned).
//
// Ports
//   clock, reset              rising-edge clock, synchronous active-high reset
//   rom_en_o, rom_adr_o       ROM read request and word address
//   rom_data_i                ROM read data, valid the cycle after rom_en_o
//   redirect_i, redirect_pc_i flush and restart fetch at redirect_pc_i
//   out_valid_o, out_ready_i  decode handshake on the queue head
//   out_instr_o, out_pc_o     head instruction and its PC
//   out_pc_plus4_o            head PC + 4 (mod 2^AW)
//   count_o                   queue occupancy
//   misalign_o                misaligned-redirect halt flag (macro only)
// ---------------------------------------------------------------------------
module ifetch_queue #(
   parameter int            AW       = 32,
   parameter int            ROM_AW   = 14,
   parameter int            DEPTH    = 4,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic                    clock,
   input  logic                    reset,
   output logic                    rom_en_o,
   output logic [ROM_AW-1:0]       rom_adr_o,
   input  logic [31:0]             rom_data_i,
   input  logic                    redirect_i,
   input  logic [AW-1:0]           redirect_pc_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [31:0]             out_instr_o,
   output logic [AW-1:0]           out_pc_o,
   output logic [AW-1:0]           out_pc_plus4_o,
   output logic [$clog2(DEPTH):0]  count_o
`ifdef IFETCH_MISALIGN_EN
   ,
   output logic                    misalign_o
`endif
);

   localparam int            PW         = $clog2(DEPTH);
   localparam int            CW         = PW + 1;
   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
   localparam logic [AW-1:0] ALIGN_MASK = ~(AW'(3));

   logic [AW-1:0] fetch_pc_p0;
   logic          vld_p1;
   logic [AW-1:0] pc_p1;

   logic [31:0]   instr_q [DEPTH];
   logic [AW-1:0] pc_q    [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] occupancy;

   logic          halt;
   logic          issue;
   logic          push;
   logic          pop;
   logic [AW-1:0] redirect_target;

`ifdef IFETCH_MISALIGN_EN
   logic misalign_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         misalign_q <= 1'b0;
      end else if (redirect_i) begin
         misalign_q <= (redirect_pc_i[1:0] != 2'b00);
      end
   end

   assign halt            = misalign_q;
   assign misalign_o      = misalign_q;
   assign redirect_target = redirect_pc_i;
`else
   assign halt            = 1'b0;
   assign redirect_target = redirect_pc_i & ALIGN_MASK;
`endif

   // In-flight requests are counted so a returning word always has a slot.
   assign occupancy = count + CW'(vld_p1);
   assign issue     = !reset && !redirect_i && !halt && (occupancy < DEPTH_C);
   // A redirect squashes the word returning this cycle.
   assign push      = vld_p1 && !redirect_i;
   assign out_valid_o = !reset && !redirect_i && (count != '0);
   assign pop       = out_valid_o && out_ready_i;

   assign rom_en_o  = issue;
   assign rom_adr_o = fetch_pc_p0[ROM_AW+1:2];

   // ---- p0: fetch PC / request issue -> p1: ROM return ----
   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc_p0 <= RESET_PC & ALIGN_MASK;
         vld_p1      <= 1'b0;
         pc_p1       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else if (redirect_i) begin
         fetch_pc_p0 <= redirect_target;
         vld_p1      <= 1'b0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else begin
         vld_p1 <= issue;
         if (issue) begin
            pc_p1       <= fetch_pc_p0;
            fetch_pc_p0 <= fetch_pc_p0 + AW'(4);
         end
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   // ---- p1: ROM return -> queue storage ----
   // Storage is cleared on reset so the head reads as zero until the first push.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
         end
      end else if (push) begin
         instr_q[wr_ptr] <= rom_data_i;
         pc_q[wr_ptr]    <= pc_p1;
      end
   end

   assign out_instr_o    = instr_q[rd_ptr];
   assign out_pc_o       = pc_q[rd_ptr];
   assign out_pc_plus4_o = pc_q[rd_ptr] + AW'(4);
   assign count_o        = count;

endmodule
